// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF = 16;
    localparam int unsigned MIN_DIV   = 2;
    localparam int unsigned CFG_CH_W  = 4;
    localparam int unsigned MAX_CH    = 16;

    typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/pending divisor, square wave and tick.
module clk_div_channel #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend_valid,
    output logic             clk_out,
    output logic             tick
);

    localparam int unsigned CW = DIV_W + 1;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pend_div;
    logic             last;
    logic             commit;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    high_len;

    // High phase length is ceil(div/2); widened so the maximum divisor cannot overflow.
    always_comb begin
        last     = (cnt == div - DIV_W'(1));
        commit   = sync || !en || last;
        cnt_inc  = {1'b0, cnt} + CW'(1);
        high_len = ({1'b0, div} + CW'(1)) >> 1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt        <= DIV_W'(DEF_DIV - 1);
            div        <= DIV_W'(DEF_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            // A write arriving while pending is empty always lands in pending first.
            pend_valid <= wr || (pend_valid && !commit);
            if (wr) begin
                pend_div <= wr_div;
            end

            if (sync || !en) begin
                // Park at the last count so the next enabled cycle wraps and rises.
                if (pend_valid) begin
                    div <= pend_div;
                    cnt <= pend_div - DIV_W'(1);
                end else begin
                    cnt <= div - DIV_W'(1);
                end
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (last) begin
                if (pend_valid) begin
                    div <= pend_div;
                end
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
            end else begin
                cnt     <= cnt + DIV_W'(1);
                clk_out <= (cnt_inc < high_len);
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_divider_bank.sv
// N-channel programmable clock divider with a shared re-phase pulse and divisor write port.
module clk_divider_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [N_CH-1:0]     ch_en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     tick
);

    logic [N_CH-1:0]   pend_valid;
    logic [MAX_CH-1:0] pend_pad;
    logic              accept;
    logic              cfg_ok;

    // Out-of-range channel indices read a zero pad bit, so they are always accepted.
    always_comb begin
        pend_pad  = MAX_CH'(pend_valid);
        cfg_ready = !pend_pad[cfg_ch];
        accept    = cfg_valid && cfg_ready;
        cfg_ok    = (cfg_div >= DIV_W'(MIN_DIV)) &&
                    ({1'b0, cfg_ch} < (CFG_CH_W + 1)'(N_CH));
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !cfg_ok;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;
        assign wr = accept && cfg_ok && (cfg_ch == CFG_CH_W'(i));

        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in     (clk_in),
            .reset      (reset),
            .en         (ch_en[i]),
            .sync       (sync),
            .wr         (wr),
            .wr_div     (cfg_div),
            .pend_valid (pend_valid[i]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank with hand-computed waveforms.
module tb_clk_divider_bank;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [3:0]  ch_en;
    logic        sync;
    logic        cfg_valid;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int n_checks = 0;
    int n_errors = 0;

    clk_divider_bank #(.N_CH(4), .DIV_W(16), .DEF_DIV(2)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [15:0] dv);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        step();
        cfg_valid = 1'b0;
    endtask

    logic [0:10] exp_c2, exp_t2;
    logic [0:16] exp_c3, exp_t3;

    initial begin
        reset = 1'b1; ch_en = 4'b0000; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 4'd0; cfg_div = 16'd0;
        step(); step();
        check_eq("rst_clk_out", 32'(clk_out), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'h0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // Default divisor 2 on channel 0
        reset = 1'b0; ch_en = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("def_clk%0d", k), 32'(clk_out[0]), 32'(k % 2));
            check_eq($sformatf("def_tick%0d", k), 32'(tick[0]), 32'(k % 2));
        end

        // Channel 1 divisor 5: high 3, low 2
        cfg_write(4'd1, 16'd5);
        step();
        ch_en[1] = 1'b1;
        exp_c2 = 11'b11100111001;
        exp_t2 = 11'b10000100001;
        for (int i = 0; i <= 10; i++) begin
            step();
            check_eq($sformatf("div5_clk%0d", i), 32'(clk_out[1]), 32'(exp_c2[i]));
            check_eq($sformatf("div5_tick%0d", i), 32'(tick[1]), 32'(exp_t2[i]));
        end

        // Channel 0: divisor 4, then write 6 mid-period at cnt=1
        ch_en[0] = 1'b0;
        cfg_write(4'd0, 16'd4);
        #1;
        check_eq("pend_ready0", 32'(cfg_ready), 32'h0);
        step();
        check_eq("commit_ready0", 32'(cfg_ready), 32'h1);
        ch_en[0] = 1'b1;
        exp_c3 = 17'b11001110001110001;
        exp_t3 = 17'b10001000001000001;
        for (int i = 0; i <= 16; i++) begin
            step();
            check_eq($sformatf("div46_clk%0d", i), 32'(clk_out[0]), 32'(exp_c3[i]));
            check_eq($sformatf("div46_tick%0d", i), 32'(tick[0]), 32'(exp_t3[i]));
            if (i == 1) begin
                cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 16'd6;
            end else begin
                cfg_valid = 1'b0;
            end
        end

        // Rejected writes
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 16'd1;
        #1;
        check_eq("rej_div_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check_eq("rej_div_err", 32'(cfg_err), 32'h1);
        check_eq("rej_div_nopend", 32'(cfg_ready), 32'h1);
        step();
        check_eq("rej_err_clear", 32'(cfg_err), 32'h0);
        cfg_valid = 1'b1; cfg_ch = 4'd7; cfg_div = 16'd9;
        #1;
        check_eq("rej_ch_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check_eq("rej_ch_err", 32'(cfg_err), 32'h1);
        step();
        check_eq("rej_ch_clear", 32'(cfg_err), 32'h0);

        // Channel 2 pending write blocks further ch2 writes until wrap; ch3 still accepted
        cfg_write(4'd2, 16'd8);
        step();
        ch_en[2] = 1'b1;
        step();
        check_eq("ch2_first_tick", 32'(tick[2]), 32'h1);
        cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_div = 16'd3;
        #1;
        check_eq("ch2_ready_free", 32'(cfg_ready), 32'h1);
        step();
        check_eq("ch2_ready_busy", 32'(cfg_ready), 32'h0);
        cfg_ch = 4'd3; cfg_div = 16'd5;
        #1;
        check_eq("ch3_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0; cfg_ch = 4'd2;
        #1;
        check_eq("ch2_still_busy", 32'(cfg_ready), 32'h0);
        for (int i = 0; i < 5; i++) step();
        check_eq("ch2_pre_wrap_tick", 32'(tick[2]), 32'h0);
        check_eq("ch2_pre_wrap_ready", 32'(cfg_ready), 32'h0);
        step();
        check_eq("ch2_wrap_tick", 32'(tick[2]), 32'h1);
        check_eq("ch2_wrap_ready", 32'(cfg_ready), 32'h1);
        step(); step();
        check_eq("ch2_div3_low", 32'(clk_out[2]), 32'h0);
        step();
        check_eq("ch2_div3_tick", 32'(tick[2]), 32'h1);
        cfg_ch = 4'd3;
        #1;
        check_eq("ch3_committed", 32'(cfg_ready), 32'h1);

        // Sync re-phases channels 0..2 (div 6, 5, 3)
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_clk_low", 32'(clk_out), 32'h0);
        check_eq("sync_tick_low", 32'(tick), 32'h0);
        step();
        check_eq("sync_rise_clk", 32'(clk_out), 32'h7);
        check_eq("sync_rise_tick", 32'(tick), 32'h7);
        step();
        check_eq("sync_hold_clk", 32'(clk_out), 32'h7);
        check_eq("sync_hold_tick", 32'(tick), 32'h0);

        // Reset mid-period clears outputs and pending state
        cfg_write(4'd0, 16'd9);
        cfg_ch = 4'd0;
        #1;
        check_eq("mid_pend_ready", 32'(cfg_ready), 32'h0);
        reset = 1'b1;
        step();
        check_eq("mid_rst_clk", 32'(clk_out), 32'h0);
        check_eq("mid_rst_tick", 32'(tick), 32'h0);
        check_eq("mid_rst_err", 32'(cfg_err), 32'h0);
        check_eq("mid_rst_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0; ch_en = 4'b0001;
        step();
        check_eq("post_rst_clk1", 32'(clk_out), 32'h1);
        step();
        check_eq("post_rst_clk2", 32'(clk_out), 32'h0);
        step();
        check_eq("post_rst_tick3", 32'(tick), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
